serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: augend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: addend, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (states SHIFT and DONE).
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE, when start=1 at a rising edge, the block SHALL:
- capture a, b and cin into internal shift/carry registers;
- clear the bit counter to 0;
- move to SHIFT.
REQ-014 In SHIFT, each rising edge SHALL process exactly one bit, LSB first:
- s = a_bit ^ b_bit ^ carry;
- carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
- s SHALL be shifted into the MSB of the internal result register;
- the operand registers SHALL shift right by 1;
- the counter SHALL increment.
REQ-015 The edge that processes bit WIDTH-1 SHALL:
- load sum with the completed result;
- load cout with the final carry;
- move the FSM to DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-017 Latency SHALL be fixed: if start is accepted at edge E0, done SHALL be high during the cycle following edge E(WIDTH), independent of operand values.
REQ-018 The result SHALL satisfy {cout,sum} = a + b + cin, evaluated modulo 2^(WIDTH+1).
REQ-019 start SHALL be ignored in SHIFT and DONE: no operand capture, no restart, no effect on the current result.
REQ-020 sum and cout SHALL change only on the REQ-015 edge, and SHALL hold their value through IDLE and through a following operation until that operation's REQ-015 edge.
REQ-021 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.
REQ-022 Changes on a, b and cin after the accepting edge SHALL NOT affect the result in progress.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide or wider, and SHALL NOT wrap before the REQ-015 transition.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, without waiting for a clock edge:
- force the FSM to IDLE;
- clear busy, done, sum, cout, the counter and all internal registers to 0.
REQ-025 Assertion of rst_n during SHIFT or DONE SHALL abort the operation, and no done pulse SHALL be produced for it.
REQ-026 After rst_n deasserts, the first start SHALL be accepted at the first rising edge on which start=1.

Verification
REQ-027 With WIDTH=8, start with a=0x5A, b=0x3C, cin=0 -> done pulses 8 edges after acceptance; sum=0x96, cout=0.
REQ-028 With WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-029 With WIDTH=8, start a=0x01, b=0x01; pulse start with a=0x80, b=0x80 during SHIFT -> single done with sum=0x02, cout=0, and no second operation.
REQ-030 With WIDTH=8, hold start=1 continuously:
- acceptances SHALL occur every WIDTH+2 edges (IDLE, 8xSHIFT, DONE);
- done SHALL be exactly one cycle wide;
- busy SHALL be low for exactly one cycle between operations.
REQ-031 Assert rst_n=0 mid-SHIFT (after 4 bits) -> busy, done, sum and cout are 0 immediately, with no clock edge required; next start with a=0x10, b=0x20 -> sum=0x30.
REQ-032 Randomised operands and cin over at least 1000 operations at WIDTH=8 and WIDTH=16 -> {cout,sum} matches the reference sum a+b+cin in every case.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that handles one bit per clock, LSB first.
// A start is accepted only in IDLE, so a new operation can begin every WIDTH+2 clocks.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] acc, rb;
  logic [CW-1:0] cnt;
  logic carry, s, c_n, last;
  assign s = acc[0] ^ rb[0] ^ carry;
  assign c_n = (acc[0] & rb[0]) | (acc[0] & carry) | (rb[0] & carry);
  assign last = cnt == CW'(WIDTH-1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = state == IDLE ? (start ? SHIFT : IDLE) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // acc holds the augend and doubles as the result register: each sum bit enters
  // at the MSB as the consumed augend bit leaves at the LSB.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      rb <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= a;
      rb <= b;
      carry <= cin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      acc <= {s, acc[WIDTH-1:1]};
      rb <= rb >> 1;
      carry <= c_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        sum <= {s, acc[WIDTH-1:1]};
        cout <= c_n;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks serial_adder at WIDTH=8 and WIDTH=16 against plain a+b+cin
// arithmetic, a fixed WIDTH+1 observed latency, start-ignore, cadence and async reset.
module tb_serial_adder;
  logic clk = 0, rst_n = 0;
  logic start8 = 0, cin8 = 0, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic start16 = 0, cin16 = 0, busy16, done16, cout16;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  int total = 0, bad = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  always #5 clk = ~clk;

  // Runs one operation from an idle negedge; lat counts negedges until done is seen (-1 = timeout).
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                     output int lat, output logic [8:0] r);
    a8 = x; b8 = y; cin8 = c; start8 = 1;
    @(negedge clk);
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (done8) begin lat = k; break; end
      @(negedge clk);
    end
    r = {cout8, sum8};
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c,
                      output int lat, output logic [16:0] r);
    a16 = x; b16 = y; cin16 = c; start16 = 1;
    @(negedge clk);
    start16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done16) begin lat = k; break; end
      @(negedge clk);
    end
    r = {cout16, sum16};
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      bad++; $display("FAIL reset8: got %h expected 0", {busy8, done8, cout8, sum8});
    end
    total++;
    if ({busy16, done16, cout16, sum16} !== 19'h0) begin
      bad++; $display("FAIL reset16: got %h expected 0", {busy16, done16, cout16, sum16});
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({busy8, done8} !== 2'b00) begin
      bad++; $display("FAIL idle_after_reset: busy/done got %b expected 00", {busy8, done8});
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
    logic vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ve [3] = '{9'h096, 9'h100, 9'h1FF};
    int lat;
    logic [8:0] r;
    for (int i = 0; i < 3; i++) begin
      op8(va[i], vb[i], vc[i], lat, r);
      total++;
      if (lat !== 9) begin bad++; $display("FAIL vec%0d_latency: got %0d expected 9", i, lat); end
      total++;
      if (r !== ve[i]) begin bad++; $display("FAIL vec%0d_result: got %h expected %h", i, r, ve[i]); end
      total++;
      if ({busy8, done8} !== 2'b00) begin
        bad++; $display("FAIL vec%0d_done_width: busy/done got %b expected 00", i, {busy8, done8});
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] prev = {cout8, sum8};
    int lat = -1;
    repeat (3) @(negedge clk);
    total++;
    if ({cout8, sum8} !== prev) begin bad++; $display("FAIL hold_idle: got %h expected %h", {cout8, sum8}, prev); end
    a8 = 8'h01; b8 = 8'h02; cin8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (4) @(negedge clk);
    total++;
    if ({cout8, sum8} !== prev) begin bad++; $display("FAIL hold_shift: got %h expected %h", {cout8, sum8}, prev); end
    for (int k = 5; k <= 30; k++) begin
      if (done8) begin lat = k; break; end
      @(negedge clk);
    end
    total++;
    if (lat !== 9 || {cout8, sum8} !== 9'h003) begin
      bad++; $display("FAIL hold_next: latency %0d result %h expected 9 and 003", lat, {cout8, sum8});
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat = -1, extra = 0, busy_seen = 0;
    logic [8:0] r;
    a8 = 8'h01; b8 = 8'h01; cin8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1; start8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int k = 3; k <= 30; k++) begin
      if (done8) begin lat = k; break; end
      @(negedge clk);
    end
    r = {cout8, sum8};
    total++;
    if (lat !== 9) begin bad++; $display("FAIL ignore_latency: got %0d expected 9", lat); end
    total++;
    if (r !== 9'h002) begin bad++; $display("FAIL ignore_result: got %h expected 002", r); end
    repeat (15) begin
      @(negedge clk);
      if (done8) extra++;
      if (busy8) busy_seen++;
    end
    total++;
    if (extra !== 0 || busy_seen !== 0) begin
      bad++; $display("FAIL ignore_no_restart: extra done %0d busy cycles %0d expected 0 and 0", extra, busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x = 8'($urandom), y = 8'($urandom);
    logic [8:0] e = {1'b0, x} + {1'b0, y};
    a8 = x; b8 = y; cin8 = 0; start8 = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      total++;
      if (done8 !== (k % 10 == 9)) begin bad++; $display("FAIL b2b_done_c%0d: got %b expected %b", k, done8, k % 10 == 9); end
      total++;
      if (busy8 !== (k % 10 != 0)) begin bad++; $display("FAIL b2b_busy_c%0d: got %b expected %b", k, busy8, k % 10 != 0); end
      if (k % 10 == 9) begin
        total++;
        if ({cout8, sum8} !== e) begin bad++; $display("FAIL b2b_result_c%0d: got %h expected %h", k, {cout8, sum8}, e); end
      end
    end
    start8 = 0;
    @(negedge clk);
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_stop: busy got %b expected 0", busy8); end
  endtask

  task automatic test_reset_abort();
    int lat, extra = 0;
    logic [8:0] r;
    op8(8'hFF, 8'h02, 1'b0, lat, r);
    total++;
    if (r !== 9'h101) begin bad++; $display("FAIL abort_pre: got %h expected 101", r); end
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (4) @(negedge clk);
    total++;
    if (busy8 !== 1'b1) begin bad++; $display("FAIL abort_midop: busy got %b expected 1", busy8); end
    #2 rst_n = 0;
    #1;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      bad++; $display("FAIL abort_async_clear: got %h expected 0", {busy8, done8, cout8, sum8});
    end
    @(negedge clk);
    rst_n = 1;
    repeat (15) begin
      @(negedge clk);
      if (done8) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL abort_no_done: got %0d done pulses expected 0", extra); end
    op8(8'h10, 8'h20, 1'b0, lat, r);
    total++;
    if (lat !== 9 || r !== 9'h030) begin
      bad++; $display("FAIL abort_restart: latency %0d result %h expected 9 and 030", lat, r);
    end
  endtask

  task automatic test_random8();
    int lat;
    logic [8:0] r, e;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] x = 8'($urandom), y = 8'($urandom);
      logic c = 1'($urandom);
      e = 9'(x) + 9'(y) + 9'(c);
      op8(x, y, c, lat, r);
      total++;
      if (lat !== 9) begin bad++; $display("FAIL rand8_latency_%0d: got %0d expected 9", i, lat); end
      total++;
      if (r !== e) begin bad++; $display("FAIL rand8_result_%0d: %h+%h+%b got %h expected %h", i, x, y, c, r, e); end
    end
  endtask

  task automatic test_random16();
    int lat;
    logic [16:0] r, e;
    for (int i = 0; i < 1001; i++) begin
      logic [15:0] x = i == 0 ? 16'hFFFF : 16'($urandom), y = i == 0 ? 16'hFFFF : 16'($urandom);
      logic c = i == 0 ? 1'b1 : 1'($urandom);
      e = 17'(x) + 17'(y) + 17'(c);
      op16(x, y, c, lat, r);
      total++;
      if (lat !== 17) begin bad++; $display("FAIL rand16_latency_%0d: got %0d expected 17", i, lat); end
      total++;
      if (r !== e) begin bad++; $display("FAIL rand16_result_%0d: %h+%h+%b got %h expected %h", i, x, y, c, r, e); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random8();
    test_random16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
